// File: rtl/load_hazard_scoreboard_pkg.sv
// Shared definitions for the load-use hazard unit: opcodes, scoreboard entry
// layout and source-register usage decode helpers.
package hazard_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam int SB_RD_W  = 5;
   localparam int SB_CNT_W = 3;

   typedef struct packed {
      logic                valid;
      logic [SB_RD_W-1:0]  rd;
      logic [SB_CNT_W-1:0] cnt;
   } sb_entry_t;

   function automatic logic uses_rs1(input logic [6:0] opcode);
      case (opcode)
         OP_R, OP_STORE, OP_BRANCH, OP_IMM, OP_LOAD, OP_JALR: return 1'b1;
         OP_LUI, OP_AUIPC, OP_JAL:                            return 1'b0;
         default:                                             return 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opcode);
      case (opcode)
         OP_R, OP_STORE, OP_BRANCH: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_hazard_scoreboard_src_decode.sv
// Decodes which source registers the ID instruction really reads.
// LOAD_HAZARD_STORE_FWD_EN: store data (rs2) is forwarded late, so it is not a source here.
module hazard_src_decode
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [31:0]       inst,
   output logic              rs1_used,
   output logic              rs2_used,
   output logic [REG_AW-1:0] rs1,
   output logic [REG_AW-1:0] rs2,
   output logic [REG_AW-1:0] rd,
   output logic              is_load
);

   logic [6:0] opcode;
   logic       unused_bits;

   assign opcode  = inst[6:0];
   assign rs1     = REG_AW'(inst[19:15]);
   assign rs2     = REG_AW'(inst[24:20]);
   assign rd      = REG_AW'(inst[11:7]);
   assign is_load = (opcode == OP_LOAD);

   assign rs1_used = uses_rs1(opcode);
`ifdef LOAD_HAZARD_STORE_FWD_EN
   assign rs2_used = uses_rs2(opcode) && (opcode != OP_STORE);
`else
   assign rs2_used = uses_rs2(opcode);
`endif

   assign unused_bits = ^{inst[31:25], inst[14:12]};

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard unit: scoreboard of in-flight loads with latency countdowns.
// Optional macro LOAD_HAZARD_STORE_FWD_EN drops store-data rs2 from the check.
module load_hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int LOAD_LAT = 1,
   parameter int NUM_ENT  = LOAD_LAT,
   parameter int REG_AW   = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  id_inst,
   input  logic                         id_valid,
   input  logic                         flush,
   input  logic                         mem_stall,
   output logic                         stall,
   output logic                         en,
   output logic                         bubble,
   output logic [$clog2(NUM_ENT+1)-1:0] pending
);

   localparam int PW = $clog2(NUM_ENT+1);

   logic              rs1_used, rs2_used, is_load;
   logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
   logic              src_hit, hazard, issue, alloc_req, sb_full, alloc_done;
   logic [PW-1:0]     pend_d;
   sb_entry_t         sb_q [NUM_ENT];
   sb_entry_t         sb_d [NUM_ENT];

   hazard_src_decode #(.REG_AW(REG_AW)) u_dec (
      .inst     (id_inst),
      .rs1_used (rs1_used),
      .rs2_used (rs2_used),
      .rs1      (dec_rs1),
      .rs2      (dec_rs2),
      .rd       (dec_rd),
      .is_load  (is_load)
   );

   // x0 is never a dependency, even though a load to x0 cannot allocate anyway
   always_comb begin
      src_hit = 1'b0;
      for (int i = 0; i < NUM_ENT; i++) begin
         if (sb_q[i].valid &&
             ((rs1_used && (dec_rs1 != '0) && (sb_q[i].rd == SB_RD_W'(dec_rs1))) ||
              (rs2_used && (dec_rs2 != '0) && (sb_q[i].rd == SB_RD_W'(dec_rs2)))))
            src_hit = 1'b1;
      end
   end

   assign hazard    = id_valid & ~flush & src_hit;
   assign stall     = hazard;
   assign en        = ~hazard;
   assign bubble    = hazard & ~mem_stall;
   assign issue     = id_valid & ~hazard & ~flush & ~mem_stall;
   assign alloc_req = issue & is_load & (dec_rd != '0);

   // Age first, then allocate, so a slot retiring this edge can be reused at once
   always_comb begin
      sb_d       = sb_q;
      sb_full    = 1'b1;
      alloc_done = 1'b0;
      pend_d     = '0;
      if (!mem_stall) begin
         for (int i = 0; i < NUM_ENT; i++) begin
            if (sb_d[i].valid) begin
               sb_d[i].cnt = sb_d[i].cnt - SB_CNT_W'(1);
               if (sb_d[i].cnt == '0) sb_d[i].valid = 1'b0;
            end
         end
      end
      for (int i = 0; i < NUM_ENT; i++) begin
         if (!sb_d[i].valid) sb_full = 1'b0;
      end
      for (int i = 0; i < NUM_ENT; i++) begin
         if (alloc_req && !alloc_done && !sb_d[i].valid) begin
            sb_d[i].valid = 1'b1;
            sb_d[i].rd    = SB_RD_W'(dec_rd);
            sb_d[i].cnt   = SB_CNT_W'(LOAD_LAT);
            alloc_done    = 1'b1;
         end
      end
      for (int i = 0; i < NUM_ENT; i++) begin
         pend_d = pend_d + PW'(sb_d[i].valid);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENT; i++) sb_q[i] <= '0;
         pending <= '0;
      end else begin
         sb_q    <= sb_d;
         pending <= pend_d;
      end
   end

   // With NUM_ENT >= LOAD_LAT an allocation always finds a free slot
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(alloc_req && sb_full));

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Bench for load_hazard_scoreboard: LOAD_LAT=1 and LOAD_LAT=3 instances share one stimulus stream.
module tb_load_hazard_scoreboard;

   localparam logic [31:0] LW5   = 32'h0000A283; // lw  x5,0(x1)
   localparam logic [31:0] LW0   = 32'h0000A003; // lw  x0,0(x1)
   localparam logic [31:0] ADD   = 32'h00728333; // add x6,x5,x7
   localparam logic [31:0] ADD0  = 32'h00000333; // add x6,x0,x0
   localparam logic [31:0] SW    = 32'h00512023; // sw  x5,0(x2)
   localparam logic [31:0] SWA5  = 32'h0002A023; // sw  x0,0(x5)
   localparam logic [31:0] LUI5  = 32'h000002B7; // lui x5,0
   localparam logic [31:0] NOP   = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] id_inst;
   logic        id_valid, flush, mem_stall;
   logic        s1, e1, b1, p1;
   logic        s3, e3, b3;
   logic [1:0]  p3;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   load_hazard_scoreboard #(.LOAD_LAT(1), .NUM_ENT(1), .REG_AW(5)) u1 (
      .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .flush(flush),
      .mem_stall(mem_stall), .stall(s1), .en(e1), .bubble(b1), .pending(p1));

   load_hazard_scoreboard #(.LOAD_LAT(3), .NUM_ENT(3), .REG_AW(5)) u3 (
      .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .flush(flush),
      .mem_stall(mem_stall), .stall(s3), .en(e3), .bubble(b3), .pending(p3));

   // Model: per DUT, a list of in-flight load destinations with remaining live cycles
   int m_rd  [2][16];
   int m_rem [2][16];
   int m_n   [2] = '{0, 0};

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic bit src_hit(input int d, input logic [31:0] inst);
      logic [6:0] op;
      int r1, r2;
      bit u1s, u2s;
      op  = inst[6:0];
      r1  = int'(inst[19:15]);
      r2  = int'(inst[24:20]);
      u1s = op inside {7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h67};
      u2s = op inside {7'h33, 7'h23, 7'h63};
`ifdef LOAD_HAZARD_STORE_FWD_EN
      if (op == 7'h23) u2s = 1'b0;
`endif
      for (int i = 0; i < m_n[d]; i++) begin
         if (u1s && r1 != 0 && r1 == m_rd[d][i]) return 1'b1;
         if (u2s && r2 != 0 && r2 == m_rd[d][i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit exp_h(input int d);
      return id_valid && !flush && src_hit(d, id_inst);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_n[0] = 0;
         m_n[1] = 0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            bit h, iss;
            int k;
            h   = exp_h(d);
            iss = id_valid && !h && !flush && !mem_stall;
            if (!mem_stall) begin
               k = 0;
               for (int i = 0; i < m_n[d]; i++) begin
                  if (m_rem[d][i] > 1) begin
                     m_rd[d][k]  = m_rd[d][i];
                     m_rem[d][k] = m_rem[d][i] - 1;
                     k++;
                  end
               end
               m_n[d] = k;
            end
            if (iss && id_inst[6:0] == 7'h03 && id_inst[11:7] != 5'd0) begin
               m_rd[d][m_n[d]]  = int'(id_inst[11:7]);
               m_rem[d][m_n[d]] = lat(d);
               m_n[d]++;
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("stall_l1",   int'(s1), int'(exp_h(0)));
      chk("en_l1",      int'(e1), int'(!exp_h(0)));
      chk("bubble_l1",  int'(b1), int'(exp_h(0) && !mem_stall));
      chk("pending_l1", int'(p1), m_n[0]);
      chk("stall_l3",   int'(s3), int'(exp_h(1)));
      chk("en_l3",      int'(e3), int'(!exp_h(1)));
      chk("bubble_l3",  int'(b3), int'(exp_h(1) && !mem_stall));
      chk("pending_l3", int'(p3), m_n[1]);
   end

   // One pipeline cycle: drive after the edge, return just after the falling edge
   task automatic cyc(input logic [31:0] inst, input logic v, input logic f, input logic ms);
      @(posedge clk);
      #1;
      id_inst   = inst;
      id_valid  = v;
      flush     = f;
      mem_stall = ms;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      repeat (4) cyc(NOP, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; id_inst = NOP; id_valid = 1'b0; flush = 1'b0; mem_stall = 1'b0;
      @(negedge clk); #1;
      chk("rst_stall", int'(s3), 0);
      chk("rst_en", int'(e3), 1);
      chk("rst_pending", int'(p3), 0);
      @(posedge clk); #1; rst = 1'b0;

      // Basic load-use pair
      cyc(LW5, 1, 0, 0); chk("A_lw_s1", int'(s1), 0); chk("A_lw_s3", int'(s3), 0);
      cyc(ADD, 1, 0, 0); chk("A_c1_s1", int'(s1), 1); chk("A_c1_b1", int'(b1), 1);
                         chk("A_c1_p1", int'(p1), 1); chk("A_c1_s3", int'(s3), 1);
      cyc(ADD, 1, 0, 0); chk("A_c2_s1", int'(s1), 0); chk("A_c2_p1", int'(p1), 0);
                         chk("A_c2_s3", int'(s3), 1);
      cyc(ADD, 1, 0, 0); chk("A_c3_s3", int'(s3), 1);
      cyc(ADD, 1, 0, 0); chk("A_c4_s3", int'(s3), 0); chk("A_c4_p3", int'(p3), 0);
      idle();

      // mem_stall freezes the countdown
      cyc(LW5, 1, 0, 0);
      cyc(ADD, 1, 0, 0); chk("B_c1_s3", int'(s3), 1); chk("B_c1_b3", int'(b3), 1);
      cyc(ADD, 1, 0, 1); chk("B_c2_s3", int'(s3), 1); chk("B_c2_b3", int'(b3), 0);
                         chk("B_c2_s1", int'(s1), 0);
      cyc(ADD, 1, 0, 1); chk("B_c3_s3", int'(s3), 1); chk("B_c3_p3", int'(p3), 1);
      cyc(ADD, 1, 0, 0); chk("B_c4_b3", int'(b3), 1);
      cyc(ADD, 1, 0, 0); chk("B_c5_s3", int'(s3), 1);
      cyc(ADD, 1, 0, 0); chk("B_c6_s3", int'(s3), 0); chk("B_c6_p3", int'(p3), 0);
      idle();

      // Store data vs store address
      cyc(LW5, 1, 0, 0);
`ifdef LOAD_HAZARD_STORE_FWD_EN
      cyc(SW, 1, 0, 0); chk("C_swdata_s1", int'(s1), 0); chk("C_swdata_s3", int'(s3), 0);
`else
      cyc(SW, 1, 0, 0); chk("C_swdata_s1", int'(s1), 1); chk("C_swdata_s3", int'(s3), 1);
`endif
      idle();
      cyc(LW5, 1, 0, 0);
      cyc(SWA5, 1, 0, 0); chk("C_swaddr_s1", int'(s1), 1); chk("C_swaddr_s3", int'(s3), 1);
      idle();

      // x0 destination and non-reading opcodes
      cyc(LW0, 1, 0, 0);
      cyc(ADD0, 1, 0, 0); chk("D_x0_s3", int'(s3), 0); chk("D_x0_p3", int'(p3), 0);
                          chk("D_x0_p1", int'(p1), 0);
      cyc(LW5, 1, 0, 0);
      cyc(LUI5, 1, 0, 0); chk("D_lui_s3", int'(s3), 0); chk("D_lui_p3", int'(p3), 1);
      idle();

      // Duplicate destinations; same-edge free and allocate on the LOAD_LAT=1 unit
      cyc(LW5, 1, 0, 0);
      cyc(LW5, 1, 0, 0); chk("E_lw2_s3", int'(s3), 0);
      cyc(ADD, 1, 0, 0); chk("E_c1_p3", int'(p3), 2); chk("E_c1_s3", int'(s3), 1);
                         chk("E_c1_p1", int'(p1), 1); chk("E_c1_s1", int'(s1), 1);
      cyc(ADD, 1, 0, 0); chk("E_c2_s3", int'(s3), 1); chk("E_c2_s1", int'(s1), 0);
      cyc(ADD, 1, 0, 0); chk("E_c3_s3", int'(s3), 1); chk("E_c3_p3", int'(p3), 1);
      cyc(ADD, 1, 0, 0); chk("E_c4_s3", int'(s3), 0); chk("E_c4_p3", int'(p3), 0);
      idle();

      // Flush kills allocation and hazard; invalid ID never stalls
      cyc(LW5, 1, 1, 0);
      cyc(ADD, 1, 0, 0); chk("F_kill_s3", int'(s3), 0); chk("F_kill_p3", int'(p3), 0);
      cyc(LW5, 1, 0, 0);
      cyc(ADD, 1, 1, 0); chk("F_fl_s3", int'(s3), 0); chk("F_fl_p3", int'(p3), 1);
      cyc(ADD, 0, 0, 0); chk("F_inv_s3", int'(s3), 0);
      cyc(ADD, 1, 0, 0); chk("F_live_s3", int'(s3), 1);
      idle();

      // Asynchronous reset in the middle of a stall
      cyc(LW5, 1, 0, 0);
      cyc(LW5, 1, 0, 0);
      cyc(ADD, 1, 0, 0); chk("G_pre_p3", int'(p3), 2); chk("G_pre_s3", int'(s3), 1);
      rst = 1'b1;
      #1;
      chk("G_rst_s3", int'(s3), 0); chk("G_rst_e3", int'(e3), 1);
      chk("G_rst_p3", int'(p3), 0); chk("G_rst_p1", int'(p1), 0);
      @(posedge clk); #1; rst = 1'b0;
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/load_hazard_scoreboard.md
Name: load_hazard_scoreboard

Overview:
- Parametrised load-use hazard unit for the in-order RISC-V pipeline; sits beside the ID stage.
- Tracks in-flight loads in a small scoreboard with per-entry latency countdowns, so memory latency is configurable rather than fixed at one cycle.
- Decodes which source registers the ID-stage instruction actually reads, stalls IF/ID and injects an ID/EX bubble while a matching load result cannot yet be forwarded.

Parameters:
- LOAD_LAT, 1, cycles from a load leaving ID until its data is forwardable to an instruction in ID (1..7).
- NUM_ENT, LOAD_LAT, scoreboard entries; must be >= LOAD_LAT.
- REG_AW, 5, architectural register address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_inst  in  32  instruction currently in ID
- id_valid  in  1  ID holds a real instruction (not a bubble)
- flush  in  1  branch/jump redirect; kills the ID instruction this cycle
- mem_stall  in  1  global pipeline freeze from the memory side
- stall  out  1  hold PC and IF/ID
- en  out  1  PC/IF-ID write enable; always ~stall
- bubble  out  1  load a NOP into ID/EX this cycle
- pending  out  $clog2(NUM_ENT+1)  number of valid scoreboard entries

Behaviour:
- Reset (async, rst=1): all entries invalid, counters 0; stall=0, en=1, bubble=0, pending=0.
- Source use by opcode id_inst[6:0]:
  - 0110011 (R), 0100011 (STORE), 1100011 (BRANCH): rs1 [19:15] and rs2 [24:20].
  - 0010011 (I-ALU), 0000011 (LOAD), 1100111 (JALR): rs1 only.
  - LUI, AUIPC, JAL, other opcodes: no sources.
- Register x0 never matches.
- Hazard (combinational): id_valid & ~flush & a used source equals rd of any valid entry.
- stall = hazard; en = ~stall; bubble = hazard & ~mem_stall.
- Issue happens when id_valid & ~stall & ~flush & ~mem_stall.
- Allocation: on issue of a LOAD with rd != 0, the lowest-index free entry gets valid=1, rd, cnt=LOAD_LAT at the clock edge. A LOAD with rd=0 allocates nothing.
- Countdown: each cycle with ~mem_stall, every valid entry decrements cnt; an entry reaching 0 becomes invalid at that edge. With mem_stall=1, all counters and valid bits hold.
- Net stall length: a dependent instruction immediately behind a load stalls exactly LOAD_LAT cycles, excluding mem_stall cycles.
- Duplicate rd: both entries stay live; the stall persists until the youngest matching entry clears.
- Free and allocate on the same edge is legal; the freed slot is reusable at that edge.
- Full scoreboard: at most one allocation per non-frozen cycle and each entry lives LOAD_LAT such cycles, so overflow is unreachable when NUM_ENT >= LOAD_LAT. Assert: allocation never requested when full.
- Flush: suppresses hazard, stall and allocation this cycle. Existing entries are not cleared; they belong to older, committed loads.
- pending is registered and updated at the same edge as the entries.
- Reset mid-operation clears all entries immediately.

Optional Feature:
- Macro: LOAD_HAZARD_STORE_FWD_EN.
- Defined: the rs2 (store data) of a STORE is excluded from the hazard check; store data is forwarded from WB in MEM. Store rs1 (address) is still checked.
- Undefined: STORE checks both rs1 and rs2.

Decomposition:
- Shared package hazard_pkg:
  - opcode localparams OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL.
  - sb_entry_t struct {valid, rd[REG_AW-1:0], cnt[2:0]}.
  - functions uses_rs1(opcode) and uses_rs2(opcode).
- One sub-module, hazard_src_decode: combinational decode of id_inst into rs1_used, rs2_used, rs1, rs2, is_load, rd.

Test Plan:
- LOAD_LAT=1: lw x5,0(x1) (0x0000A283) then add x6,x5,x7 (0x00728333) -> stall=1, bubble=1 for exactly 1 cycle after lw issues; pending 1 -> 0.
- LOAD_LAT=3: same pair -> stall held 3 cycles. Assert mem_stall for 2 of those cycles -> stall held 5 cycles total, bubble=0 during the frozen cycles.
- lw x5 then sw x5,0(x2) (0x00512023) -> 1-cycle stall with macro undefined; no stall with LOAD_HAZARD_STORE_FWD_EN defined. sw x5 as address via rs1 stalls in both builds.
- lw x0,0(x1) (0x0000A003) then add using x0 -> no allocation, pending=0, no stall. lui x5 (0x000002B7) after lw x5 -> no stall.
- LOAD_LAT=3: back-to-back lw x5, lw x5, then add x6,x5,x7 -> pending=2, stall until the second entry clears. flush with lw in ID -> no allocation, stall=0.
- rst asserted mid-stall with pending=2 -> immediately stall=0, en=1, pending=0, no clock edge required.
